// File: rtl/hdc_pkg.sv
// Shared constants and types for the HDC encoder datapath.
package hdc_pkg;

  localparam int unsigned FEATURE_COUNT = 617;
  localparam int unsigned HV_DIM        = 5000;
  localparam int unsigned DIMS_PER_CC   = 500;
  localparam int unsigned NUM_CHUNKS    = HV_DIM / DIMS_PER_CC;
  localparam int unsigned PC_W          = $clog2(FEATURE_COUNT + 1);

  localparam logic [3:0] CTR_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } enc_state_t;

endpackage

// File: rtl/enc_popcount.sv
// Population count of one dimension's bound bits, computed as two half counts.
// With ENC_BUNDLE_PC_PIPE_EN the half counts are registered before the final add.
module enc_popcount #(
  parameter int unsigned Width = 617,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
`ifdef ENC_BUNDLE_PC_PIPE_EN
  input  logic            clk,
  input  logic            rst_n,
`endif
  input  logic [Width-1:0] din,
  output logic [CntW-1:0]  count
);

  localparam int unsigned LoW = Width / 2;

  logic [CntW-1:0] lo_sum, hi_sum;

  always_comb begin
    lo_sum = '0;
    for (int unsigned i = 0; i < LoW; i++) begin
      lo_sum = lo_sum + CntW'(din[i]);
    end
  end

  always_comb begin
    hi_sum = '0;
    for (int unsigned i = LoW; i < Width; i++) begin
      hi_sum = hi_sum + CntW'(din[i]);
    end
  end

`ifdef ENC_BUNDLE_PC_PIPE_EN
  logic [CntW-1:0] lo_q, hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_sum;
      hi_q <= hi_sum;
    end
  end

  assign count = lo_q + hi_q;
`else
  assign count = lo_sum + hi_sum;
`endif

endmodule

// File: rtl/enc_bundle_ctrl.sv
// Chunk sequencer and bundler: walks the mux through all chunks, thresholds per-dim
// popcounts into hv_out, and hands the result off on valid/ready. Option: ENC_BUNDLE_PC_PIPE_EN.
module enc_bundle_ctrl
  import hdc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [9:0]               thr,
  input  logic [FEATURE_COUNT-1:0] mux_in [DIMS_PER_CC],
  output logic [3:0]               ctr,
  output logic                     busy,
  output logic [HV_DIM-1:0]        hv_out,
  output logic                     hv_valid,
  input  logic                     hv_ready
);

`ifdef ENC_BUNDLE_PC_PIPE_EN
  localparam logic DRAIN_LAST = 1'b1;
`else
  localparam logic DRAIN_LAST = 1'b0;
`endif

  enc_state_t      state_q;
  logic [9:0]      thr_q;
  logic            drain_cnt_q;

  logic [PC_W-1:0] pc_d [DIMS_PER_CC];
  logic [PC_W-1:0] pc_q [DIMS_PER_CC];
  logic            s1_vld_q;
  logic [3:0]      s1_idx_q;
  logic [DIMS_PER_CC-1:0] cmp;

  // Control FSM; ctr parks at CTR_IDLE outside RUN so the mux outputs zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr         <= CTR_IDLE;
      busy        <= 1'b0;
      hv_valid    <= 1'b0;
      thr_q       <= '0;
      drain_cnt_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ctr     <= 4'd0;
            busy    <= 1'b1;
            thr_q   <= thr;
          end
        end
        RUN: begin
          if (ctr == 4'(NUM_CHUNKS - 1)) begin
            state_q     <= DRAIN;
            ctr         <= CTR_IDLE;
            drain_cnt_q <= 1'b0;
          end else begin
            ctr <= ctr + 4'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q  <= DONE;
            hv_valid <= 1'b1;
          end else begin
            drain_cnt_q <= ~drain_cnt_q;
          end
        end
        DONE: begin
          if (hv_ready) begin
            state_q  <= IDLE;
            hv_valid <= 1'b0;
            busy     <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar d = 0; d < DIMS_PER_CC; d++) begin : g_pc
    enc_popcount #(
      .Width (FEATURE_COUNT),
      .CntW  (PC_W)
    ) u_pc (
`ifdef ENC_BUNDLE_PC_PIPE_EN
      .clk   (clk),
      .rst_n (rst_n),
`endif
      .din   (mux_in[d]),
      .count (pc_d[d])
    );
  end

  // Chunk index and valid travel alongside the popcount pipeline.
`ifdef ENC_BUNDLE_PC_PIPE_EN
  logic       s0_vld_q;
  logic [3:0] s0_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_vld_q <= 1'b0;
      s0_idx_q <= '0;
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
    end else begin
      s0_vld_q <= (state_q == RUN);
      s0_idx_q <= ctr;
      s1_vld_q <= s0_vld_q;
      s1_idx_q <= s0_idx_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_idx_q <= '0;
    end else begin
      s1_vld_q <= (state_q == RUN);
      s1_idx_q <= ctr;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < DIMS_PER_CC; d++) begin
        pc_q[d] <= '0;
      end
    end else begin
      for (int unsigned d = 0; d < DIMS_PER_CC; d++) begin
        pc_q[d] <= pc_d[d];
      end
    end
  end

  always_comb begin
    cmp = '0;
    for (int unsigned d = 0; d < DIMS_PER_CC; d++) begin
      cmp[d] = (pc_q[d] >= thr_q);
    end
  end

  // Only the slice for the chunk in flight is rewritten; others keep their contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_out <= '0;
    end else if (s1_vld_q) begin
      for (int unsigned c = 0; c < NUM_CHUNKS; c++) begin
        if (s1_idx_q == 4'(c)) begin
          hv_out[c*DIMS_PER_CC +: DIMS_PER_CC] <= cmp;
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_bundle_ctrl.sv
// Directed bench for enc_bundle_ctrl with a queue-based scoreboard of expected hypervectors.
module tb_enc_bundle_ctrl;
  import hdc_pkg::*;

`ifdef ENC_BUNDLE_PC_PIPE_EN
  localparam int LatEdges = 12;
`else
  localparam int LatEdges = 11;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [9:0]               thr;
  logic [FEATURE_COUNT-1:0] mux_in [DIMS_PER_CC];
  logic [3:0]               ctr;
  logic                     busy;
  logic [HV_DIM-1:0]        hv_out;
  logic                     hv_valid;
  logic                     hv_ready;

  int mode;
  int fill_id;
  int checks;
  int errors;
  logic [FEATURE_COUNT-1:0] rnd [NUM_CHUNKS][DIMS_PER_CC];
  logic [HV_DIM-1:0]        sb [$];

  enc_bundle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .thr      (thr),
    .mux_in   (mux_in),
    .ctr      (ctr),
    .busy     (busy),
    .hv_out   (hv_out),
    .hv_valid (hv_valid),
    .hv_ready (hv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mode 0: all ones; 1: chunk k dims have popcount 300+k; 2: random data.
  function automatic logic [FEATURE_COUNT-1:0] gen(input logic [3:0] c, input int d);
    logic [FEATURE_COUNT-1:0] v;
    v = '0;
    if (c != 4'hF) begin
      if (mode == 0) v = '1;
      else if (mode == 1) for (int i = 0; i < 300 + int'(c); i++) v[i] = 1'b1;
      else v = rnd[c][d];
    end
    return v;
  endfunction

  always @(ctr or mode or fill_id) begin
    for (int d = 0; d < DIMS_PER_CC; d++) mux_in[d] = gen(ctr, d);
  end

  function automatic logic [HV_DIM-1:0] model(input logic [9:0] t);
    logic [HV_DIM-1:0] m;
    m = '0;
    for (int c = 0; c < NUM_CHUNKS; c++)
      for (int d = 0; d < DIMS_PER_CC; d++)
        m[c*DIMS_PER_CC + d] = ($countones(gen(4'(c), d)) >= int'(t));
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hv(input string tag, input logic [HV_DIM-1:0] obs,
                        input logic [HV_DIM-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got ones=%0d expected ones=%0d differing bits=%0d",
             tag, $countones(obs), $countones(exp), $countones(obs ^ exp));
    end
  endtask

  task automatic do_run(input logic [9:0] t, input int m, input int hold, input bit extra);
    int edges;
    logic [HV_DIM-1:0] exp;
    logic [HV_DIM-1:0] got;
    mode = m;
    hv_ready = (hold == 0);
    exp = model(t);
    sb.push_back(exp);
    @(posedge clk); #1;
    start = 1'b1;
    thr = t;
    @(posedge clk); #1;
    start = 1'b0;
    thr = 10'h2AA;  // latched copy must be used, not the live input
    edges = 0;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      chk("ctr_walk", 32'(ctr), 32'(k));
      start = (extra && k == 3);
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk("ctr_after_run", 32'(ctr), 32'hF);
    while (!hv_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("valid_rise", 32'(hv_valid), 32'd1);
    chk("latency", 32'(edges), 32'(LatEdges));
    chk("busy_done", 32'(busy), 32'd1);
    chk("ctr_done", 32'(ctr), 32'hF);
    got = hv_out;
    if (sb.size() > 0) chk_hv("hv_out", got, sb.pop_front());
    else chk("sb_underflow", 32'(sb.size()), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("valid_hold", 32'(hv_valid), 32'd1);
      chk("ctr_hold", 32'(ctr), 32'hF);
      chk_hv("hv_hold", hv_out, got);
    end
    hv_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(hv_valid), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
    if (extra) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        chk("no_second_run", 32'({busy, ctr}), 32'h0F);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mode = 0;
    fill_id = 0;
    rst_n = 1'b0;
    start = 1'b0;
    thr = '0;
    hv_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctr", 32'(ctr), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(hv_valid), 32'd0);
    chk_hv("rst_hv", hv_out, '0);
    rst_n = 1'b1;

    for (int c = 0; c < NUM_CHUNKS; c++) begin
      for (int d = 0; d < DIMS_PER_CC; d++) begin
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < FEATURE_COUNT; i++) begin
          if (i % 32 == 0) r = $urandom;
          rnd[c][d][i] = r[i % 32];
        end
      end
    end
    fill_id = 1;

    do_run(10'd617, 0, 0, 1'b0);
    chk_hv("all_ones_617", hv_out, '1);

    do_run(10'd305, 1, 0, 1'b0);
    chk_hv("split_lo", {2500'b0, hv_out[2499:0]}, '0);
    chk_hv("split_hi", {hv_out[4999:2500], 2500'b0}, {{2500{1'b1}}, 2500'b0});

    do_run(10'd0, 1, 0, 1'b0);
    chk_hv("thr0_ones", hv_out, '1);
    do_run(10'd1023, 0, 0, 1'b0);
    chk_hv("thr1023_zeros", hv_out, '0);

    do_run(10'd308, 2, 5, 1'b0);
    do_run(10'd302, 1, 0, 1'b1);

    // Reset in the middle of a run.
    mode = 0;
    @(posedge clk); #1;
    start = 1'b1;
    thr = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && ctr != 4'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("reach_ctr4", 32'(ctr), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctr", 32'(ctr), 32'hF);
    chk("midrst_valid", 32'(hv_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk_hv("midrst_hv", hv_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_run(10'd310, 2, 0, 1'b0);
    do_run(10'd300, 2, 2, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
